// File: rtl/branch_cond_unit.sv
// branch_cond_unit: NZCV flag register, branch condition evaluation, registered taken decision and saturating taken counter
module branch_cond_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             set_flags,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             eval_valid,
  input  logic [1:0]       eval_kind,
  input  logic [3:0]       br_cond,
  input  logic             reg_zero,
  input  logic             clr_count,
  output logic [3:0]       flags,
  output logic             taken_valid,
  output logic             taken,
  output logic [CNT_W-1:0] taken_count
);
  logic [3:0] alu_flags, eff;
  logic       n, z, c, v, cond_hit, decision;
  assign alu_flags = {alu_negative, alu_zero, alu_carry, alu_overflow};
  // same-cycle bypass so a branch right behind a flag setter sees the new flags
  assign eff = set_flags ? alu_flags : flags;
  assign {n, z, c, v} = eff;
  always_comb begin
    cond_hit = 1'b1;
    case (br_cond)
      4'h0: cond_hit = z;
      4'h1: cond_hit = !z;
      4'h2: cond_hit = c;
      4'h3: cond_hit = !c;
      4'h4: cond_hit = n;
      4'h5: cond_hit = !n;
      4'h6: cond_hit = v;
      4'h7: cond_hit = !v;
      4'h8: cond_hit = c & !z;
      4'h9: cond_hit = !c | z;
      4'hA: cond_hit = n == v;
      4'hB: cond_hit = n != v;
      4'hC: cond_hit = !z & (n == v);
      4'hD: cond_hit = z | (n != v);
      default: cond_hit = 1'b1;
    endcase
  end
  assign decision = eval_kind == 2'b00 ? cond_hit :
                    eval_kind == 2'b01 ? reg_zero :
                    eval_kind == 2'b10 ? !reg_zero : 1'b1;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags       <= '0;
      taken_valid <= 1'b0;
      taken       <= 1'b0;
      taken_count <= '0;
    end else if (!stall) begin
      if (set_flags) flags <= alu_flags;
      taken_valid <= eval_valid;
      taken       <= eval_valid & decision;
      if (clr_count) taken_count <= '0;
      else if (eval_valid && decision && !(&taken_count)) taken_count <= taken_count + CNT_W'(1);
    end
  end
endmodule
